// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues instruction-memory reads, strobes
// the instruction register and hands instructions to decode via valid/ready.
module fetch_sequencer #(
  parameter int              INST_W   = 36,
  parameter int              ADDR_W   = 32,
  parameter int              PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data,
  output logic              IR_wr,
  output logic              IR_rd,
  output logic [INST_W-1:0] ir_data,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              dec_ready,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_VALID = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

  state_t            state, state_nxt;
  logic [7:0]        tmo_cnt;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] inst_pc_p1;
  logic [INST_W-1:0] ir_data_p1;
  logic              err_q;

  logic in_wait, tmo_hit, tmo_fire, go_req, xfer, capture, cnt_run;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_wait  = (state == S_REQ) || (state == S_DRAIN);
  assign tmo_hit  = in_wait && !mem_ack && (tmo_cnt >= TMO_LAST);
  // A redirect out of REQ takes priority over the timeout; DRAIN still times out.
  assign tmo_fire = tmo_hit && !((state == S_REQ) && flush);
  assign go_req   = start && !err_q;
  assign xfer     = (state == S_VALID) && dec_ready && !stall;
  assign capture  = (state == S_REQ) && mem_ack && !flush;
  assign cnt_run  = in_wait && !mem_ack &&
                    ((state_nxt == S_REQ) || (state_nxt == S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (go_req) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (flush)         state_nxt = mem_ack ? S_REQ : S_DRAIN;
        else if (mem_ack)  state_nxt = S_LOAD;
        else if (tmo_fire) state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (flush) state_nxt = go_req ? S_REQ : S_IDLE;
        else       state_nxt = S_VALID;
      end
      S_VALID: begin
        if (flush)     state_nxt = go_req ? S_REQ : S_IDLE;
        else if (xfer) state_nxt = start ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (mem_ack)       state_nxt = S_REQ;
        else if (tmo_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    IR_wr      = 1'b0;
    IR_rd      = 1'b0;
    inst_valid = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_p0;
      end
      S_LOAD:  IR_wr = 1'b1;
      S_VALID: begin
        IR_rd      = 1'b1;
        inst_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage 0: program counter and request-timeout tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0   <= RESET_PC;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (flush)                pc_p0 <= flush_pc;
      else if (state == S_LOAD) pc_p0 <= pc_p0 + STEP;
      tmo_cnt <= cnt_run ? sat_inc(tmo_cnt) : 8'd0;
      if (tmo_fire) err_q <= 1'b1;
    end
  end

  // Stage 1: fetched instruction and its address, captured on the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_data_p1 <= '0;
      inst_pc_p1 <= '0;
    end else if (capture) begin
      ir_data_p1 <= mem_data;
      inst_pc_p1 <= pc_p0;
    end
  end

  assign pc          = pc_p0;
  assign ir_data     = ir_data_p1;
  assign inst_pc     = inst_pc_p1;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table-driven fetches checked through a scoreboard,
// plus hand-written flush, timeout, wrap and asynchronous-reset sequences.
module tb_fetch_sequencer;

  localparam int INST_W = 36;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stall, flush, mem_ack, dec_ready;
  logic [ADDR_W-1:0] flush_pc;
  logic [INST_W-1:0] mem_data;
  logic              mem_req, IR_wr, IR_rd, inst_valid, timeout_err, busy;
  logic [ADDR_W-1:0] mem_addr, pc, inst_pc;
  logic [INST_W-1:0] ir_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                delay;
    logic [INST_W-1:0] data;
    int                nstall;
  } vec_t;
  vec_t vecs[5];

  fetch_sequencer #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .PC_STEP(1), .RESET_PC('0), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .flush(flush),
    .flush_pc(flush_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .IR_wr(IR_wr), .IR_rd(IR_rd),
    .ir_data(ir_data), .pc(pc), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .dec_ready(dec_ready), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_check();
    sb_t e;
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_ir_data", 64'(ir_data), 64'(e.data));
      chk("sb_inst_pc", 64'(inst_pc), 64'(e.addr));
    end
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_outs"}, {58'd0, mem_req, IR_wr, IR_rd, inst_valid, timeout_err, busy}, 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'd0);
    chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
    chk({tag, "_ir_data"}, 64'(ir_data), 64'd0);
  endtask

  // One full fetch: wait for request, ack after delay, walk LOAD/VALID, transfer.
  task automatic do_fetch(input logic [ADDR_W-1:0] exp_addr, input int delay,
                          input logic [INST_W-1:0] data, input int nstall);
    logic [ADDR_W-1:0] nxt;
    int n;
    nxt = exp_addr + 32'd1;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(mem_req), 64'd1);
    chk("req_addr", 64'(mem_addr), 64'(exp_addr));
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("req_hold", 64'(mem_req), 64'd1);
      chk("req_hold_addr", 64'(mem_addr), 64'(exp_addr));
    end
    mem_ack  = 1'b1;
    mem_data = data;
    sb.push_back('{exp_addr, data});
    if (nstall > 0) stall = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("load_irwr", {62'd0, IR_wr, inst_valid}, 64'b10);
    chk("load_req_low", 64'(mem_req), 64'd0);
    chk("load_pc", 64'(pc), 64'(exp_addr));
    tick();
    chk("valid_flags", {61'd0, inst_valid, IR_rd, IR_wr}, 64'b110);
    chk("valid_pc", 64'(pc), 64'(nxt));
    for (int k = 1; k < nstall; k++) begin
      tick();
      chk("stall_hold", {61'd0, inst_valid, IR_rd, mem_req}, 64'b110);
      chk("stall_ir", 64'(ir_data), 64'(data));
    end
    stall = 1'b0;
    sb_pop_check();
    tick();
    chk("after_xfer_req", 64'(mem_req), 64'(start));
    chk("after_xfer_busy", 64'(busy), 64'(start));
  endtask

  initial begin
    int n;
    vecs[0] = '{32'd0, 2, 36'h0_1234_5678, 0};
    vecs[1] = '{32'd1, 0, 36'hF_FFFF_FFFF, 0};
    vecs[2] = '{32'd2, 0, 36'h8_0000_0001, 0};
    vecs[3] = '{32'd3, 0, 36'h5_A5A5_A5A5, 5};
    vecs[4] = '{32'd4, 1, 36'h0_0000_0000, 0};

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    flush_pc = '0; mem_ack = 1'b0; mem_data = '0; dec_ready = 1'b1;
    #2;
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b1;
    tick();

    for (int i = 0; i < 5; i++)
      do_fetch(vecs[i].addr, vecs[i].delay, vecs[i].data, vecs[i].nstall);

    // Redirect while a request is outstanding: drain the late ack, refetch.
    chk("pre_flush_addr", 64'(mem_addr), 64'd5);
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    chk("drain_state", {62'd0, mem_req, busy}, 64'b01);
    chk("drain_pc", 64'(pc), 64'h100);
    for (int k = 0; k < 2; k++) begin
      chk("drain_noreq", {62'd0, mem_req, IR_wr}, 64'd0);
      tick();
    end
    mem_ack = 1'b1; mem_data = 36'h0_DEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("drain_exit", {62'd0, mem_req, IR_wr}, 64'b10);
    chk("drain_exit_addr", 64'(mem_addr), 64'h100);
    do_fetch(32'h100, 0, 36'h1_0000_0100, 0);

    // Flush while the instruction is held for decode.
    mem_ack = 1'b1; mem_data = 36'h7_7777_7777;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("vflush_pre", 64'(inst_valid), 64'd1);
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("vflush_drop", {61'd0, inst_valid, IR_rd, mem_req}, 64'b001);
    chk("vflush_addr", 64'(mem_addr), 64'h200);
    do_fetch(32'h200, 0, 36'h2_0000_0200, 0);

    // Flush coinciding with an ack: data dropped, PC wraps on the next fetch.
    mem_ack = 1'b1; mem_data = 36'h3_3333_3333;
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    chk("ackflush_state", {62'd0, mem_req, IR_wr}, 64'b10);
    chk("ackflush_addr", 64'(mem_addr), 64'hFFFF_FFFF);
    do_fetch(32'hFFFF_FFFF, 0, 36'h9_8765_4321, 0);

    // start dropped mid-fetch: instruction completes, then idle.
    start = 1'b0;
    do_fetch(32'h0, 1, 36'h4_4444_4444, 0);
    mem_ack = 1'b1; mem_data = 36'h6_6666_6666;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_ignored", {62'd0, busy, IR_wr}, 64'd0);

    // Request timeout with no ack ever.
    start = 1'b1;
    tick();
    n = mem_req ? 1 : 0;
    while (mem_req && n < 40) begin
      tick();
      if (mem_req) n++;
    end
    chk("tmo_cycles", 64'(n), 64'd15);
    chk("tmo_flags", {61'd0, timeout_err, mem_req, busy}, 64'b100);
    tick(); tick(); tick();
    chk("tmo_sticky", {61'd0, timeout_err, mem_req, busy}, 64'b100);

    // Asynchronous reset while holding a valid instruction.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_clears_err", 64'(timeout_err), 64'd0);
    tick();
    chk("restart_addr", 64'(mem_addr), 64'd0);
    mem_ack = 1'b1; mem_data = 36'hA_BCDE_F012; stall = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("arst_pre_valid", 64'(inst_valid), 64'd1);
    chk("arst_pre_ir", 64'(ir_data), 64'hA_BCDE_F012);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("arst");
    stall = 1'b0;
    tick();
    rst_n = 1'b1;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
